imem_line_responder: RTL and testbench

//  Memory-side responder for the 128-bit line-fill interface driven by the fetch stage / i_cache.

---
 rtl/imem_line_responder.sv | 126 ++++++++++++
 tb/tb_imem_line_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_line_responder.sv
// imem_line_responder: memory-side responder for the 128-bit line-fill port.
// One line request is accepted at a time and served from a 32-bit word store,
// one word per beat. Completion of reads and writes is a one-cycle mem_rvalid_o.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for mem_cs_i; request fields are latched on accept
//   S_WAIT | optional idle delay before the first beat (down-counter)
//   S_BEAT | four beats, one word read into mem_rdata_o or written to store
//   S_RESP | mem_rvalid_o high for exactly one cycle, then back to idle
module imem_line_responder #(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  mem_addr_i,
    input  logic [127:0] mem_wdata_i,
    input  logic         mem_we_i,
    input  logic         mem_cs_i,
    output logic [127:0] mem_rdata_o,
    output logic         mem_rvalid_o,
    output logic         busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Line index width; a 4-word store has a single line, so keep one dummy bit.
    localparam int LW = (AW > 2) ? AW - 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     beat_q;
    logic [3:0]     wait_q;
    logic [LW-1:0]  line_q;
    logic           we_q;
    logic [127:0]   wdata_q;
    logic [AW-1:0]  idx;
    logic           accept;
    logic           addr_unused;

    logic [31:0]    store [DEPTH_WORDS];

    // Low nibble and bits above the store range are deliberately ignored (lines alias).
    assign addr_unused = ^mem_addr_i;

    assign accept = (state_q == S_IDLE) && mem_cs_i;

    generate
        if (AW > 2) begin : g_idx_line
            assign idx = {line_q, beat_q};
        end else begin : g_idx_beat
            assign idx = beat_q;
        end
    endgenerate

    // State register; reset aborts any request in flight without a response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (mem_cs_i) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_BEAT;
            S_WAIT: if (wait_q == 4'd0) state_d = S_BEAT;
            S_BEAT: if (beat_q == 2'd3) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch; later changes on the request inputs are ignored while busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            line_q  <= mem_addr_i[LW+3:4];
            we_q    <= mem_we_i;
            wdata_q <= mem_wdata_i;
        end
    end

    // Wait down-counter (loaded on accept) and beat counter (wraps to 0 after beat 3).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= 4'd0;
            beat_q <= 2'd0;
        end else begin
            if (accept)
                wait_q <= 4'(WAIT_CYCLES - 1);
            else if (state_q == S_WAIT && wait_q != 4'd0)
                wait_q <= wait_q - 4'd1;
            if (state_q == S_BEAT)
                beat_q <= beat_q + 2'd1;
        end
    end

    // Read beats fill the line word by word; writes leave the last read line intact.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            mem_rdata_o <= '0;
        else if (state_q == S_BEAT && !we_q)
            mem_rdata_o[{beat_q, 5'd0} +: 32] <= store[idx];
    end

    // Word store is not reset; beats committed before a reset are kept.
    always_ff @(posedge clk_i) begin
        if (state_q == S_BEAT && we_q)
            store[idx] <= wdata_q[{beat_q, 5'd0} +: 32];
    end

    assign mem_rvalid_o = (state_q == S_RESP);
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: three instances cover the default
// configuration, WAIT_CYCLES=3 and a 16-word store (line aliasing).
module tb_imem_line_responder;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cs     [3];
    logic         we     [3];
    logic [31:0]  addr   [3];
    logic [127:0] wdata  [3];
    logic [127:0] rdata  [3];
    logic         rvalid [3];
    logic         busy   [3];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int rv_cyc;

    localparam logic [127:0] LINE0 = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] LINEW = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] LINEB = 128'hB0B0B0B3_B0B0B0B2_B0B0B0B1_B0B0B0B0;
    localparam logic [127:0] LINEC = 128'hC0000003_C0000002_C0000001_C0000000;
    localparam logic [127:0] LINED = 128'hD0000003_D0000002_D0000001_D0000000;
    localparam logic [127:0] OLD   = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    localparam logic [127:0] NEW   = 128'h55550003_55550002_55550001_55550000;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    imem_line_responder u_d0 (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_addr_i(addr[0]), .mem_wdata_i(wdata[0]), .mem_we_i(we[0]), .mem_cs_i(cs[0]),
        .mem_rdata_o(rdata[0]), .mem_rvalid_o(rvalid[0]), .busy_o(busy[0])
    );

    imem_line_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_addr_i(addr[1]), .mem_wdata_i(wdata[1]), .mem_we_i(we[1]), .mem_cs_i(cs[1]),
        .mem_rdata_o(rdata[1]), .mem_rvalid_o(rvalid[1]), .busy_o(busy[1])
    );

    imem_line_responder #(.DEPTH_WORDS(16)) u_d16 (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_addr_i(addr[2]), .mem_wdata_i(wdata[2]), .mem_we_i(we[2]), .mem_cs_i(cs[2]),
        .mem_rdata_o(rdata[2]), .mem_rvalid_o(rvalid[2]), .busy_o(busy[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Raises cs and waits (bounded) for rvalid; returns at
    // the negedge where rvalid is seen, cs still high. Inputs are scrambled after
    // accept so that only latched request fields can produce the right result.
    task automatic req(input int d, input logic w, input logic [31:0] a,
                       input logic [127:0] wd, output int lat, output int nbusy);
        cs[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        lat = -1; nbusy = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_i);
            if (n == 1) begin
                addr[d] = ~a; wdata[d] = ~wd; we[d] = ~w;
            end
            if (busy[d]) nbusy++;
            if (rvalid[d]) begin
                lat = n;
                rv_cyc = cyc;
                break;
            end
        end
    endtask

    // Cycle after rvalid: drop cs, confirm the pulse was single and the block is idle.
    task automatic finish_req(input int d);
        @(negedge clk_i);
        cs[d] = 1'b0;
        check("single_pulse", 128'(rvalid[d]), 128'd0);
        check("idle_busy", 128'(busy[d]), 128'd0);
    endtask

    initial begin
        int lat, nb, t1, rv_seen;
        rst_i = 1'b1;
        for (int d = 0; d < 3; d++) begin
            cs[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (2) @(negedge clk_i);
        for (int d = 0; d < 3; d++) begin
            check("rst_rvalid", 128'(rvalid[d]), 128'd0);
            check("rst_busy", 128'(busy[d]), 128'd0);
            check("rst_rdata", rdata[d], 128'd0);
        end
        rst_i = 1'b0;
        @(negedge clk_i);

        // Preload line 0 and read it back with the default latency.
        req(0, 1'b1, 32'h0, LINE0, lat, nb);
        check("wr0_lat", 128'(lat), 128'd5);
        finish_req(0);
        req(0, 1'b0, 32'h0, '0, lat, nb);
        check("rd0_lat", 128'(lat), 128'd5);
        check("rd0_busy_cycles", 128'(nb), 128'd5);
        check("rd0_data", rdata[0], LINE0);
        finish_req(0);

        // Write leaves rdata alone; read with a nonzero low nibble hits the same line.
        req(0, 1'b1, 32'h10, LINEW, lat, nb);
        check("wr10_lat", 128'(lat), 128'd5);
        check("wr10_rdata_held", rdata[0], LINE0);
        finish_req(0);
        req(0, 1'b0, 32'h1C, '0, lat, nb);
        check("rd1c_data", rdata[0], LINEW);
        finish_req(0);

        // WAIT_CYCLES=3: longer latency, cs held into the idle cycle not re-served.
        req(1, 1'b1, 32'h40, LINEB, lat, nb);
        check("w3_wr_lat", 128'(lat), 128'd8);
        finish_req(1);
        req(1, 1'b0, 32'h40, '0, lat, nb);
        check("w3_rd_lat", 128'(lat), 128'd8);
        check("w3_busy_cycles", 128'(nb), 128'd8);
        check("w3_rd_data", rdata[1], LINEB);
        finish_req(1);
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (rvalid[1]) rv_seen = 1;
        end
        check("w3_no_second", 128'(rv_seen), 128'd0);

        // 16-word store: line 4 aliases line 0, line 5 aliases line 1.
        req(2, 1'b1, 32'h0, LINEC, lat, nb);
        finish_req(2);
        req(2, 1'b0, 32'h40, '0, lat, nb);
        check("d16_wrap_40", rdata[2], LINEC);
        finish_req(2);
        req(2, 1'b1, 32'h50, LINED, lat, nb);
        finish_req(2);
        req(2, 1'b0, 32'h10, '0, lat, nb);
        check("d16_wrap_10", rdata[2], LINED);
        finish_req(2);

        // Back-to-back reads: cs re-asserted in the idle cycle after rvalid.
        req(0, 1'b0, 32'h0, '0, lat, nb);
        check("b2b_first", rdata[0], LINE0);
        t1 = rv_cyc;
        @(negedge clk_i);
        req(0, 1'b0, 32'h10, '0, lat, nb);
        check("b2b_second", rdata[0], LINEW);
        check("b2b_gap", 128'(rv_cyc - t1), 128'd6);
        finish_req(0);

        // Reset during beat 2 of a write: beats 0-1 committed, 2-3 keep old data.
        req(0, 1'b1, 32'h20, OLD, lat, nb);
        finish_req(0);
        cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = NEW;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rst_mid_busy", 128'(busy[0]), 128'd0);
        check("rst_mid_rvalid", 128'(rvalid[0]), 128'd0);
        check("rst_mid_rdata", rdata[0], 128'd0);
        cs[0] = 1'b0;
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (rvalid[0]) rv_seen = 1;
        end
        rst_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (rvalid[0]) rv_seen = 1;
        end
        check("rst_no_rvalid", 128'(rv_seen), 128'd0);
        req(0, 1'b0, 32'h20, '0, lat, nb);
        check("rst_partial_line", rdata[0], {OLD[127:64], NEW[63:0]});
        finish_req(0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
